mcac_cu_seq: RTL and testbench
==============================

Name: mcac_cu_seq

Overview:
Parametrised multi-channel control unit/sequencer for the MCAC codec datapath.
- On each frame sync, walks channels 0..NUM_CH-1 in order.
- Per channel, drives LOAD, then COMPUTE for STEPS cycles, then STORE.
- Emits channel index, step index and phase strobes to the datapath and state RAM.
- Flags frame overrun; carries the standard scan/test ports for DFT insertion.

Parameters:
NUM_CH, 4, number of channels sequenced per frame (1..32)
STEPS, 16, COMPUTE cycles per channel (2..256)
CH_W, $clog2(NUM_CH) min 1, channel index width
ST_W, $clog2(STEPS), step index width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
scan_in0  input  1  scan chain input
scan_enable  input  1  scan shift enable
test_mode  input  1  DFT test mode
scan_out0  output  1  scan chain output
frame_sync  input  1  single-cycle frame start pulse
dp_ready  input  1  datapath/RAM ready; stalls LOAD and STORE
ch_idx  output  CH_W  current channel
step_idx  output  ST_W  current COMPUTE step
load_stb  output  1  state RAM read strobe
comp_en  output  1  datapath compute enable
store_stb  output  1  state RAM write strobe
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after last channel STORE
overrun  output  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0.
- scan_out0: functional 0 until scan insertion; scan_in0, scan_enable, test_mode have no functional effect.
- FSM states: IDLE, LOAD, COMPUTE, STORE, NEXT.
- IDLE:
  - frame_sync=1 moves to LOAD on the next cycle with ch_idx=0, busy=1.
- LOAD:
  - load_stb=1 while in LOAD.
  - Stays in LOAD while dp_ready=0.
  - dp_ready=1 moves to COMPUTE with step_idx=0.
- COMPUTE:
  - comp_en=1 every cycle; dp_ready is ignored.
  - step_idx increments each cycle.
  - At step_idx=STEPS-1, moves to STORE.
  - Exactly STEPS comp_en cycles per channel.
- STORE:
  - store_stb=1 while in STORE; stays while dp_ready=0.
  - dp_ready=1 goes to NEXT.
- NEXT (one cycle):
  - If ch_idx=NUM_CH-1: go to IDLE, frame_done=1 in that cycle, ch_idx returns to 0, busy=0 from the next cycle.
  - Otherwise: ch_idx+1, go to LOAD.
- Minimum frame length with dp_ready held high: NUM_CH*(STEPS+3) cycles from the first LOAD cycle to the frame_done cycle inclusive.
- frame_sync while busy=1 (any non-IDLE state):
  - Sets overrun=1.
  - The current frame continues undisturbed; the sync is dropped (no queued restart).
  - overrun clears only on reset.
- frame_sync in the same cycle as the NEXT of the last channel: counts as overrun and is dropped.
- Counter wrap: step_idx and ch_idx never exceed STEPS-1 and NUM_CH-1 for non-power-of-two values; compare-and-clear, no natural wrap.
- Outputs are registered, decoded from the state register; no combinational path from dp_ready to the strobes.

Optional Feature:
MCAC_CU_CHAN_MASK_EN
- Defined:
  - Adds input chan_mask [NUM_CH-1:0], sampled into a register on the accepted frame_sync.
  - Channels whose mask bit is 0 are skipped: no LOAD/COMPUTE/STORE for that channel.
  - Skipping is done in NEXT, and from IDLE for the first channel, by advancing to the next set bit.
  - An all-zero mask gives frame_done one cycle after frame_sync, with busy=1 for that one cycle.
- Undefined: no port; every channel is processed.

Decomposition:
- Package mcac_cu_pkg holds:
  - state enum (IDLE, LOAD, COMPUTE, STORE, NEXT);
  - default NUM_CH/STEPS constants;
  - width-function helper for CH_W/ST_W.
- Sub-module mcac_cu_cnt: generic modulo-N counter with enable, clear and terminal-count output.
  - Instanced twice: step counter and channel counter.

Test Plan:
1. Reset: hold reset=0 with frame_sync toggling -> all outputs 0; release -> IDLE, busy=0.
2. NUM_CH=4, STEPS=16, dp_ready=1, one frame_sync -> channel order 0,1,2,3; 16 comp_en cycles per channel; frame_done at cycle 76 from the first LOAD; one load_stb and one store_stb per channel.
3. dp_ready=0 for 5 cycles in ch 2 LOAD and 3 cycles in ch 2 STORE -> load_stb held 6 cycles, store_stb held 4 cycles, comp_en count unchanged, frame_done delayed by 8 cycles.
4. Second frame_sync 20 cycles into a frame -> overrun=1 and sticky; current frame completes normally; no second frame starts.
5. NUM_CH=3, STEPS=5 -> step_idx 0..4, ch_idx 0..2, no illegal values; reset asserted mid-COMPUTE -> immediate IDLE, outputs 0.
6. MCAC_CU_CHAN_MASK_EN, mask=4'b1010 -> only ch 1 and ch 3 processed; mask=0 -> frame_done one cycle after frame_sync.

Source files
------------

// File: rtl/mcac_cu_pkg.sv
// mcac_cu_pkg: shared types and helpers for the MCAC control unit/sequencer.
// Holds the sequencer state encoding, the default channel/step counts and the
// index-width helper used to size ch_idx and step_idx.
package mcac_cu_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_STEPS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_STORE   = 3'd3,
        ST_NEXT    = 3'd4
    } cu_state_e;

    // Width of an index that counts 0..n-1, never narrower than one bit.
    function automatic int cu_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcac_cu_cnt.sv
// mcac_cu_cnt: modulo-N up counter with enable, synchronous clear, parallel
// load and a terminal-count flag. Used for both the step and channel index.
module mcac_cu_cnt #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (cnt == LAST);

    // Count 0..N-1 with compare-and-clear so non-power-of-two N never yields an illegal index.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mcac_cu_seq.sv
// mcac_cu_seq: multi-channel control unit/sequencer for the MCAC datapath.
// On each accepted frame sync it walks the channels in order, driving LOAD,
// STEPS cycles of COMPUTE and STORE per channel, then raises frame_done.
// A sync that arrives while a frame is running sets the sticky overrun flag
// and is dropped. Optional build macro MCAC_CU_CHAN_MASK_EN adds chan_mask,
// which skips channels whose mask bit is clear.
module mcac_cu_seq
    import mcac_cu_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int STEPS  = DEF_STEPS,
    parameter int CH_W   = cu_width(NUM_CH),
    parameter int ST_W   = cu_width(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_in0,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    input  logic              frame_sync,
    input  logic              dp_ready,
`ifdef MCAC_CU_CHAN_MASK_EN
    input  logic [NUM_CH-1:0] chan_mask,
`endif
    output logic [CH_W-1:0]   ch_idx,
    output logic [ST_W-1:0]   step_idx,
    output logic              load_stb,
    output logic              comp_en,
    output logic              store_stb,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    cu_state_e       state;
    cu_state_e       next_state;

    logic [CH_W-1:0] ch_cnt;
    logic            ch_tc;
    logic            ch_inc;
    logic            ch_clr;
    logic            ch_load;
    logic [CH_W-1:0] ch_load_val;
    logic            last_ch;

    logic [ST_W-1:0] st_cnt;
    logic            st_tc;

    logic            overrun_q;

    // DFT ports are placeholders until scan insertion; they have no functional effect.
    logic            unused_dft;
    assign unused_dft = scan_in0 ^ scan_enable ^ test_mode;
    assign scan_out0  = 1'b0;

    // Step counter: advances every COMPUTE cycle and wraps to 0 after STEPS-1.
    mcac_cu_cnt #(
        .N (STEPS),
        .W (ST_W)
    ) u_step_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (state == ST_COMPUTE),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (st_cnt),
        .tc       (st_tc)
    );

    // Channel counter: moves on leaving NEXT, returns to 0 at end of frame.
    mcac_cu_cnt #(
        .N (NUM_CH),
        .W (CH_W)
    ) u_ch_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (ch_inc),
        .clr      (ch_clr),
        .load     (ch_load),
        .load_val (ch_load_val),
        .cnt      (ch_cnt),
        .tc       (ch_tc)
    );

`ifdef MCAC_CU_CHAN_MASK_EN
    logic [NUM_CH-1:0] mask_q;
    logic              first_found;
    logic [CH_W-1:0]   first_ch;
    logic              nxt_found;
    logic [CH_W-1:0]   nxt_ch;
    logic              unused_ch_tc;

    // The mask scan replaces the counter's own terminal count in this build.
    assign unused_ch_tc = ch_tc;

    // Capture the channel mask on the sync that starts a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if ((state == ST_IDLE) && frame_sync) begin
            mask_q <= chan_mask;
        end
    end

    // Find the lowest enabled channel (frame start) and the next enabled channel above ch_idx.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        nxt_found   = 1'b0;
        nxt_ch      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_cnt))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    assign last_ch = !nxt_found;
`else
    assign last_ch = ch_tc;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and channel-counter control.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        ch_inc      = 1'b0;
        ch_clr      = 1'b0;
        ch_load     = 1'b0;
        ch_load_val = '0;
        case (state)
            ST_IDLE: begin
                if (frame_sync) begin
`ifdef MCAC_CU_CHAN_MASK_EN
                    if (first_found) begin
                        next_state  = ST_LOAD;
                        ch_load     = 1'b1;
                        ch_load_val = first_ch;
                    end else begin
                        // Empty mask: a single NEXT cycle closes the frame.
                        next_state = ST_NEXT;
                    end
`else
                    next_state = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                if (dp_ready) begin
                    next_state = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                // dp_ready is deliberately ignored while computing.
                if (st_tc) begin
                    next_state = ST_STORE;
                end
            end
            ST_STORE: begin
                if (dp_ready) begin
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (last_ch) begin
                    next_state = ST_IDLE;
                    ch_clr     = 1'b1;
                end else begin
                    next_state = ST_LOAD;
`ifdef MCAC_CU_CHAN_MASK_EN
                    ch_load     = 1'b1;
                    ch_load_val = nxt_ch;
`else
                    ch_inc      = 1'b1;
`endif
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun: any sync seen outside IDLE is recorded and otherwise dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_q <= 1'b0;
        end else if (frame_sync && (state != ST_IDLE)) begin
            overrun_q <= 1'b1;
        end
    end

    // Outputs decode only flops (state, counters), so dp_ready never reaches a strobe combinationally.
    assign load_stb   = (state == ST_LOAD);
    assign comp_en    = (state == ST_COMPUTE);
    assign store_stb  = (state == ST_STORE);
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_NEXT) && last_ch;
    assign ch_idx     = ch_cnt;
    assign step_idx   = st_cnt;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mcac_cu_seq.sv
// tb_mcac_cu_seq: self-checking bench for mcac_cu_seq. Two instances are
// exercised (NUM_CH=4/STEPS=16 and NUM_CH=3/STEPS=5); a select line routes
// stimulus to one and muxes its outputs to a common observation view.
// Expected frame shape is derived from channel count, step count, mask and
// the dp_ready stalls the bench itself injects.
`timescale 1ns/1ps
module tb_mcac_cu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        frame_sync;
    logic        dp_ready;
    logic        sel;
    logic [31:0] mask;
    logic        scan_in0;
    logic        scan_enable;
    logic        test_mode;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: 4 channels, 16 steps
    logic       fs4, dr4, so4, ld4, cp4, st4, bz4, fd4, ov4;
    logic [1:0] ch4;
    logic [3:0] sp4;
    // Instance B: 3 channels, 5 steps
    logic       fs3, dr3, so3, ld3, cp3, st3, bz3, fd3, ov3;
    logic [1:0] ch3;
    logic [2:0] sp3;

    assign fs4 = frame_sync & ~sel;
    assign fs3 = frame_sync & sel;
    assign dr4 = sel ? 1'b1 : dp_ready;
    assign dr3 = sel ? dp_ready : 1'b1;

    mcac_cu_seq #(.NUM_CH(4), .STEPS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (so4),
        .frame_sync  (fs4),
        .dp_ready    (dr4),
`ifdef MCAC_CU_CHAN_MASK_EN
        .chan_mask   (mask[3:0]),
`endif
        .ch_idx      (ch4),
        .step_idx    (sp4),
        .load_stb    (ld4),
        .comp_en     (cp4),
        .store_stb   (st4),
        .busy        (bz4),
        .frame_done  (fd4),
        .overrun     (ov4)
    );

    mcac_cu_seq #(.NUM_CH(3), .STEPS(5)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (so3),
        .frame_sync  (fs3),
        .dp_ready    (dr3),
`ifdef MCAC_CU_CHAN_MASK_EN
        .chan_mask   (mask[2:0]),
`endif
        .ch_idx      (ch3),
        .step_idx    (sp3),
        .load_stb    (ld3),
        .comp_en     (cp3),
        .store_stb   (st3),
        .busy        (bz3),
        .frame_done  (fd3),
        .overrun     (ov3)
    );

    // Common observation view of the selected instance
    logic       o_ld, o_cp, o_st, o_bz, o_fd, o_ov, o_so;
    logic [4:0] o_ch;
    logic [7:0] o_sp;
    assign o_ld = sel ? ld3 : ld4;
    assign o_cp = sel ? cp3 : cp4;
    assign o_st = sel ? st3 : st4;
    assign o_bz = sel ? bz3 : bz4;
    assign o_fd = sel ? fd3 : fd4;
    assign o_ov = sel ? ov3 : ov4;
    assign o_so = sel ? so3 : so4;
    assign o_ch = sel ? 5'(ch3) : 5'(ch4);
    assign o_sp = sel ? 8'(sp3) : 8'(sp4);

    // DFT inputs wiggle randomly throughout; they must have no functional effect.
    initial begin
        scan_in0    = 1'b0;
        scan_enable = 1'b0;
        test_mode   = 1'b0;
        forever begin
            @(negedge clk);
            scan_in0    = 1'($urandom_range(0, 1));
            scan_enable = 1'($urandom_range(0, 1));
            test_mode   = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-channel observations of the most recent frame
    int ld_cnt[32];
    int st_cnt[32];
    int cp_cnt[32];
    int ld_stall[32];
    int st_stall[32];
    int order[$];

    // Start a frame from IDLE and score it. mode 0: dp_ready high; mode 1: random
    // dp_ready; mode 2: ch 2 LOAD stalled 5 cycles and STORE stalled 3 cycles.
    // sync_at: cycle (0 = first LOAD) at which an extra frame_sync is driven, -1 for none.
    task automatic run_frame(input string name, input int mode, input int sync_at, output int len);
        int  n_ch  = sel ? 3 : 4;
        int  steps = sel ? 5 : 16;
        int  exp_order[$];
        int  stalls   = 0;
        int  cyc      = 0;
        int  exp_len;
        bit  done     = 1'b0;
        bit  prev_ld  = 1'b0;
        bit  step_ok  = 1'b1;
        bit  range_ok = 1'b1;
        bit  excl_ok  = 1'b1;
        bit  cnt_ok   = 1'b1;
        bit  order_ok;
        logic rdy;
        for (int c = 0; c < 32; c++) begin
            ld_cnt[c] = 0; st_cnt[c] = 0; cp_cnt[c] = 0; ld_stall[c] = 0; st_stall[c] = 0;
        end
        order.delete();
        for (int c = 0; c < n_ch; c++) if (mask[c]) exp_order.push_back(c);
        len = 0;
        frame_sync = 1'b1;
        dp_ready   = 1'b1;
        @(negedge clk);
        while (!done && cyc < 2000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = !((o_ld && o_ch == 5'd2 && ld_cnt[2] < 5) ||
                                 (o_st && o_ch == 5'd2 && st_cnt[2] < 3));
            endcase
            dp_ready   = rdy;
            frame_sync = (cyc == sync_at);
            if (o_ld) begin
                if (!prev_ld) order.push_back(int'(o_ch));
                ld_cnt[o_ch]++;
                if (!rdy) ld_stall[o_ch]++;
            end
            if (o_st) begin
                st_cnt[o_ch]++;
                if (!rdy) st_stall[o_ch]++;
            end
            if (o_cp) begin
                if (int'(o_sp) != cp_cnt[o_ch]) step_ok = 1'b0;
                cp_cnt[o_ch]++;
            end
            if ((o_ld || o_st) && !rdy) stalls++;
            if (int'(o_ch) >= n_ch || int'(o_sp) >= steps) range_ok = 1'b0;
            if (int'(o_ld) + int'(o_cp) + int'(o_st) > 1 || !o_bz) excl_ok = 1'b0;
            prev_ld = o_ld;
            if (o_fd) begin
                done = 1'b1;
                len  = cyc + 1;
            end
            cyc++;
            @(negedge clk);
        end
        frame_sync = 1'b0;
        dp_ready   = 1'b1;
        exp_len = (exp_order.size() == 0) ? 1 : exp_order.size() * (steps + 3) + stalls;
        check({name, "_done_seen"}, 32'(done), 1);
        check({name, "_len"}, len, exp_len);
        order_ok = (order.size() == exp_order.size());
        if (order_ok) for (int k = 0; k < order.size(); k++) if (order[k] != exp_order[k]) order_ok = 1'b0;
        check({name, "_ch_order"}, 32'(order_ok), 1);
        for (int c = 0; c < n_ch; c++) begin
            if (mask[c]) begin
                if (cp_cnt[c] != steps || ld_cnt[c] != ld_stall[c] + 1 || st_cnt[c] != st_stall[c] + 1)
                    cnt_ok = 1'b0;
            end else if (cp_cnt[c] != 0 || ld_cnt[c] != 0 || st_cnt[c] != 0) begin
                cnt_ok = 1'b0;
            end
        end
        check({name, "_phase_counts"}, 32'(cnt_ok), 1);
        check({name, "_step_seq"}, 32'(step_ok), 1);
        check({name, "_idx_range"}, 32'(range_ok), 1);
        check({name, "_strobe_excl"}, 32'(excl_ok), 1);
        check({name, "_idle_after"}, {o_bz, o_fd, o_ld, o_cp, o_st, o_ch}, 0);
    endtask

    // Watch a few idle cycles and confirm no frame starts on its own.
    task automatic expect_idle(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (o_bz || o_ld) seen = 1'b1;
            @(negedge clk);
        end
        check({name, "_no_restart"}, 32'(seen), 0);
    endtask

    initial begin
        int len;
        reset      = 1'b0;
        frame_sync = 1'b0;
        dp_ready   = 1'b0;
        sel        = 1'b0;
        mask       = '1;

        // Reset held with frame_sync toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            frame_sync = ~frame_sync;
            dp_ready   = 1'($urandom_range(0, 1));
        end
        check("rst_outs_a", {so4, ld4, cp4, st4, bz4, fd4, ov4, ch4, sp4}, 0);
        check("rst_outs_b", {so3, ld3, cp3, st3, bz3, fd3, ov3, ch3, sp3}, 0);
        @(negedge clk);
        frame_sync = 1'b0;
        dp_ready   = 1'b1;
        reset      = 1'b1;
        @(negedge clk);
        check("post_rst_busy", o_bz, 0);
        check("post_rst_overrun", o_ov, 0);

        // Nominal frame and stalled frame on the 4x16 instance
        run_frame("nominal", 0, -1, len);
        check("nominal_len76", len, 76);
        check("nominal_overrun", o_ov, 0);
        run_frame("stall", 2, -1, len);
        check("stall_len84", len, 84);
        check("stall_ld2", ld_cnt[2], 6);
        check("stall_st2", st_cnt[2], 4);
        check("stall_cp2", cp_cnt[2], 16);
        for (int i = 0; i < 4; i++) run_frame("rand_a", 1, -1, len);
        check("rand_a_overrun", o_ov, 0);

        // Overrun: extra sync 20 cycles in
        run_frame("ovr", 0, 20, len);
        check("ovr_len76", len, 76);
        check("ovr_flag", o_ov, 1);
        expect_idle("ovr", 6);
        check("ovr_sticky", o_ov, 1);
        reset = 1'b0;
        @(negedge clk);
        check("ovr_cleared_by_rst", o_ov, 0);
        reset = 1'b1;
        @(negedge clk);

        // Sync coinciding with the last channel's NEXT
        run_frame("lastnext", 0, 75, len);
        check("lastnext_flag", o_ov, 1);
        expect_idle("lastnext", 6);

        // 3x5 instance
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sel   = 1'b1;
        @(negedge clk);
        run_frame("ch3", 0, -1, len);
        check("ch3_len24", len, 24);
        for (int i = 0; i < 3; i++) run_frame("rand_b", 1, -1, len);

        // Reset asserted mid-COMPUTE
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_comp_en", o_cp, 1);
        check("mid_step", o_sp, 1);
        #1 reset = 1'b0;
        #1 check("mid_rst_outs", {so3, ld3, cp3, st3, bz3, fd3, ov3, ch3, sp3}, 0);
        @(negedge clk);
        reset = 1'b1;
        expect_idle("mid_rst", 4);

`ifdef MCAC_CU_CHAN_MASK_EN
        sel  = 1'b0;
        mask = 32'h0000_000A;
        run_frame("mask1010", 0, -1, len);
        check("mask1010_len", len, 38);
        mask = 32'h0;
        run_frame("mask0", 0, -1, len);
        check("mask0_len", len, 1);
        mask = '1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
